// File: rtl/adder_share_ctrl.sv
// Time-shares one external combinational adder among four requesters: arbitrate, register operands,
// capture sum/carry one cycle later, pulse ack. Build option: ADDER_SHARE_FIXED_PRIO_EN (fixed priority).
module adder_share_ctrl #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*n-1:0] req_a,
  input  logic [4*n-1:0] req_b,
  input  logic [3:0]     req_cin,
  output logic [n-1:0]   add_a,
  output logic [n-1:0]   add_b,
  output logic           add_cin,
  input  logic [n-1:0]   add_s,
  input  logic           add_cout,
  output logic [3:0]     ack,
  output logic [n-1:0]   res_s,
  output logic           res_cout,
  output logic [1:0]     gnt_id,
  output logic           busy,
  output logic [15:0]    op_count
);

  // state | meaning
  // IDLE  | waiting for a request; adder input registers hold
  // EXEC  | operands on the adder, sum settling for one full cycle
  // RESP  | result captured, ack strobed to the owner
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [1:0] win;

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] last;
  logic [1:0] idx;
  logic       found;

  // Search starts just after the previous winner; the 2-bit add wraps mod 4.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (state == IDLE && req != 4'b0000) begin
      last <= win;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      res_s    <= '0;
      res_cout <= 1'b0;
      ack      <= 4'b0000;
      gnt_id   <= 2'd0;
      busy     <= 1'b0;
      op_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            add_a   <= req_a[int'(win)*n +: n];
            add_b   <= req_b[int'(win)*n +: n];
            add_cin <= req_cin[win];
            gnt_id  <= win;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_s    <= add_s;
          res_cout <= add_cout;
          ack      <= 4'b0001 << gnt_id;
          state    <= RESP;
        end
        RESP: begin
          ack      <= 4'b0000;
          busy     <= 1'b0;
          op_count <= op_count + 16'd1;
          state    <= IDLE;
        end
        default: begin
          ack   <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: queued expectations per requester, independent arbitration/sum model,
// and a negedge monitor that scores every ack.
module tb_adder_share_ctrl;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [4*N-1:0] req_a = '0;
  logic [4*N-1:0] req_b = '0;
  logic [3:0]     req_cin = 4'b0000;
  logic [N-1:0]   add_a, add_b, add_s, res_s;
  logic           add_cin, add_cout, res_cout, busy;
  logic [3:0]     ack;
  logic [1:0]     gnt_id;
  logic [15:0]    op_count;

  always #5 clk = ~clk;

  // The shared adder attached to the controller.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  adder_share_ctrl #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .ack(ack), .res_s(res_s), .res_cout(res_cout), .gnt_id(gnt_id), .busy(busy),
    .op_count(op_count)
  );

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[4][$];
  logic [3:0] hist[$];
  int         ack_t[$];
  logic [1:0] m_last = 2'd3;
  logic [15:0] m_cnt = 16'd0;
  bit         chk_cnt = 1'b0;

  always @(posedge clk) hist.push_back(req);

  function automatic int pick(input logic [1:0] last, input logic [3:0] r);
`ifdef ADDER_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (int'(last) + k) % 4;
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: winner is recomputed from the req vector seen at the grant edge.
  always @(negedge clk) begin
    int   w;
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      m_last  = 2'd3;
      m_cnt   = 16'd0;
      chk_cnt = 1'b0;
    end else begin
      if (chk_cnt) begin
        chk("op_count", 64'(op_count), 64'(m_cnt));
        chk_cnt = 1'b0;
      end
      if (ack != 4'b0000) begin
        w = (hist.size() >= 2) ? pick(m_last, hist[hist.size()-2]) : -1;
        if (w < 0) begin
          tests++; fails++;
          $display("FAIL ack_no_request: got ack %b, expected none", ack);
        end else begin
          chk("ack", 64'(ack), 64'(4'b0001 << w));
          chk("gnt_id", 64'(gnt_id), 64'(w));
          chk("busy_resp", 64'(busy), 64'd1);
          if (exp_q[w].size() == 0) begin
            tests++; fails++;
            $display("FAIL ack_unexpected: got ack %b, expected no pending op", ack);
          end else begin
            e = exp_q[w].pop_front();
            chk("res_s", 64'(res_s), 64'(e.s));
            chk("res_cout", 64'(res_cout), 64'(e.c));
          end
          m_last = 2'(w);
        end
        m_cnt   = m_cnt + 16'd1;
        chk_cnt = 1'b1;
        ack_t.push_back(hist.size());
      end
    end
  end

  task automatic issue(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] sum;
    exp_t       e;
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_cin[i]      = c;
    req[i]          = 1'b1;
    sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    e.s = sum[N-1:0];
    e.c = sum[N];
    exp_q[i].push_back(e);
  endtask

  // Requesters drop req on their ack and may immediately re-request with pct% probability.
  task automatic run(input int cycles, input int pct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) req[i] = 1'b0;
        if (!req[i] && int'($urandom_range(99)) < pct)
          issue(i, $urandom, $urandom, 1'($urandom_range(1)));
      end
    end
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) p += exp_q[i].size();
    return p;
  endfunction

  task automatic drain();
    int budget;
    budget = 200;
    while (pending() != 0 && budget > 0) begin
      run(1, 0);
      budget--;
    end
    if (budget == 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d ops pending, expected 0", pending());
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end
    run(2, 0);
  endtask

  task automatic chk_rst_outs();
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);
    chk("rst_res_s", 64'(res_s), 64'd0);
    chk("rst_res_cout", 64'(res_cout), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst_outs();
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    issue(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    drain();

    // All four requesting back to back: acks must be spaced exactly 3 cycles apart.
    n0 = ack_t.size();
    for (int i = 0; i < 4; i++) issue(i, $urandom, $urandom, 1'($urandom_range(1)));
    run(16, 100);
    chk("rr_ack_count", 64'(ack_t.size() - n0 >= 5), 64'd1);
    for (int k = n0 + 1; k < ack_t.size(); k++)
      chk("ack_spacing", 64'(ack_t[k] - ack_t[k-1]), 64'd3);
    drain();

    // Winner's operand changes after grant must not affect the result.
    issue(0, 32'd5, 32'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_a[N-1:0] = 32'd9;
    drain();

    // Requester withdraws while granted; op still completes with ack.
    issue(3, $urandom, $urandom, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req[3] = 1'b0;
    drain();

    // Reset during EXEC drops the in-flight op.
    issue(0, $urandom, $urandom, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst_outs();
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, $urandom, $urandom, 1'b1);
    drain();

    run(3000, 25);
    drain();

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.op_count;
    issue(1, $urandom, $urandom, 1'b0);
    drain();
    issue(2, $urandom, $urandom, 1'b1);
    drain();
    chk("op_count_wrap", 64'(op_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
